instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL take parameter ADDR_WIDTH, default 5, as the instruction-memory word-index width.
REQ-002 The block SHALL take parameter RESET_PC, default 32'h0000_0000, as the first fetch byte address.
REQ-003 Clock and reset: one clock, clk; reset is synchronous and active-low, rst_n.
REQ-004 Port clk, input, 1: rising-edge clock for all state.
REQ-005 Port rst_n, input, 1: synchronous active-low reset.
REQ-006 Port imem_addr, output, ADDR_WIDTH: word index to instruction memory, equal to pc[ADDR_WIDTH+1:2], combinational from the PC register.
REQ-007 Port imem_ins, input, 32: instruction word returned combinationally by memory in the same cycle.
REQ-008 Port redirect_valid, input, 1: branch/jump redirect request.
REQ-009 Port redirect_pc, input, 32: redirect target byte address.
REQ-010 Port out_valid, output, 1: the output stage holds a fetched instruction.
REQ-011 Port out_ready, input, 1: the decoder accepts the output stage.
REQ-012 Port out_pc, output, 32: byte address of out_ins.
REQ-013 Port out_ins, output, 32: fetched instruction word.
REQ-014 Port fault, output, 1: sticky misaligned-redirect fault.

Function
REQ-015 The state machine SHALL have three states: BOOT, RUN and FAULT.
REQ-016 BOOT SHALL last exactly one cycle after reset release, SHALL perform no capture, and SHALL then go to RUN.
REQ-017 In RUN, "advance" SHALL mean out_valid==0 or out_ready==1.
REQ-018 On advance without redirect, the block SHALL load {pc, imem_ins} into out_pc/out_ins, set out_valid=1 and set pc = pc+4.
REQ-019 When out_valid==1 and out_ready==0, the block SHALL hold pc, out_pc, out_ins and out_valid stable, with no capture.
REQ-020 On a handshake with no new capture possible, out_valid SHALL clear; this case does not arise in RUN, so a handshake always refills in the same edge, giving 1 instruction per cycle.
REQ-021 redirect_valid in RUN SHALL have priority over advance and stall: pc = {redirect_pc[31:2], 2'b00}, out_valid = 0 on the next edge, with no capture in that cycle.
REQ-022 After a redirect, the target instruction SHALL appear at out_valid one cycle later (redirect-to-valid latency: 2 edges).
REQ-023 A redirect with out_valid==1 and out_ready==1 in the same cycle SHALL treat the handshake as completed and the old instruction as consumed, not replayed.
REQ-024 Address wrap: imem_addr SHALL use truncation only, so the PC wraps modulo 2^(ADDR_WIDTH+2) at the memory; the 32-bit pc SHALL wrap at 2^32 with no error.
REQ-025 redirect_valid in BOOT SHALL be ignored.
REQ-026 FAULT SHALL hold out_valid=0 and fault=1, freeze pc, and ignore all inputs until reset.

Reset
REQ-027 When rst_n==0 at a clock edge, the block SHALL set state=BOOT, pc=RESET_PC, out_valid=0, out_pc=0, out_ins=32'h0000_0013 (NOP) and fault=0.
REQ-028 Reset asserted mid-stall or mid-redirect SHALL discard all in-flight state; the first captured instruction after reset SHALL be at RESET_PC.

Configuration
REQ-029 The macro IFETCH_MISALIGN_TRAP_EN SHALL control the misaligned-redirect trap.
REQ-030 With IFETCH_MISALIGN_TRAP_EN defined, a RUN-state redirect with redirect_pc[1:0]!=0 SHALL move to FAULT on that edge, with pc unchanged.
REQ-031 With IFETCH_MISALIGN_TRAP_EN undefined, redirect_pc[1:0] SHALL be ignored (forced to 0), the FAULT state SHALL be unreachable, and fault SHALL be tied 0.

Verification
Bench memory model: imem_ins = 32'hA000_0000 | imem_addr.
REQ-032 Reset and stream: rst_n low 2 cycles, then high, out_ready=1 -> out_valid rises on the 2nd edge after release; out_pc/out_ins sequence 0/A0000000, 4/A0000001, 8/A0000002, one per cycle.
REQ-033 Backpressure: hold out_ready=0 for 3 cycles while out_pc=8 -> out_pc=8 and out_ins=A0000002 stable; after release, next out_pc=C, with no skip or duplicate.
REQ-034 Redirect: redirect_valid=1, redirect_pc=0x40 while out_valid=1 -> out_valid=0 next cycle, then out_pc=0x40 and out_ins=A0000010, then 0x44.
REQ-035 Wrap: redirect to 0x7C (ADDR_WIDTH=5) -> out_ins A000001F at out_pc 0x7C, then out_pc 0x80 with out_ins A0000000.
REQ-036 Misaligned: redirect_pc=0x42 -> with the macro: fault=1 and out_valid stays 0 until reset; without the macro: out_pc=0x40 and fault=0.
REQ-037 Reset mid-stall: out_ready=0 and rst_n=0 for 1 cycle -> out_valid=0, then the stream restarts at out_pc=0.

Source files
------------

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Single-stage instruction fetch unit. A byte-address PC register drives the
// instruction-memory word index; the memory returns the instruction in the same
// cycle, and it is captured into a one-entry output stage. The output stage
// uses a valid/ready handshake toward the decoder. Branch/jump redirects
// replace the PC and flush the output stage.
//
// Handshake: out_valid/out_ready follow strict valid/ready rules. A transfer
// happens on a rising edge where both are high. While out_valid is high and
// out_ready is low, out_pc/out_ins/out_valid hold stable. out_valid never
// depends combinationally on out_ready.
//
// Configuration macro:
//   IFETCH_MISALIGN_TRAP_EN - when defined, a redirect to a byte address that
//                             is not word aligned enters a sticky FAULT state.
//                             When undefined, redirect_pc[1:0] is ignored and
//                             fault is tied low.
//
// Parameters:
//   ADDR_WIDTH - instruction-memory word-index width (default 5)
//   RESET_PC   - first fetch byte address (default 0)
//
// Ports:
//   clk            in   rising-edge clock
//   rst_n          in   synchronous active-low reset
//   imem_addr      out  word index to memory, pc[ADDR_WIDTH+1:2]
//   imem_ins       in   instruction word for imem_addr, same cycle
//   redirect_valid in   redirect request
//   redirect_pc    in   redirect target byte address
//   out_valid      out  output stage holds an instruction
//   out_ready      in   decoder accepts the output stage
//   out_pc         out  byte address of out_ins
//   out_ins        out  fetched instruction word
//   fault          out  sticky misaligned-redirect fault
//
// The FSM state is held in the signal 'state' (type ifetch_state_t) so that
// checkers can bind to it hierarchically.
// -----------------------------------------------------------------------------
module instruction_fetch #(
    parameter int          ADDR_WIDTH = 5,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [31:0]           imem_ins,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_pc,
    output logic [31:0]           out_ins,
    output logic                  fault
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } ifetch_state_t;

    ifetch_state_t state, state_nxt;
    logic [31:0]   pc, pc_nxt;
    logic          valid_nxt;
    logic [31:0]   out_pc_nxt;
    logic [31:0]   out_ins_nxt;
    logic          fault_nxt;
    logic          advance;

    // Truncation only: the memory sees the PC modulo 2^(ADDR_WIDTH+2).
    assign imem_addr = pc[ADDR_WIDTH+1:2];

    assign advance = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= BOOT;
            pc        <= RESET_PC;
            out_valid <= 1'b0;
            out_pc    <= 32'h0000_0000;
            out_ins   <= NOP;
            fault     <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            out_valid <= valid_nxt;
            out_pc    <= out_pc_nxt;
            out_ins   <= out_ins_nxt;
            fault     <= fault_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        valid_nxt   = out_valid;
        out_pc_nxt  = out_pc;
        out_ins_nxt = out_ins;
        fault_nxt   = fault;

        unique case (state)
            BOOT: begin
                // One idle cycle after reset; redirects are ignored here.
                state_nxt = RUN;
            end

            RUN: begin
                if (redirect_valid) begin
                    // Redirect wins over advance and stall. Any instruction in
                    // the output stage is dropped (or counts as consumed if it
                    // handshakes this same edge).
                    valid_nxt = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
                    if (redirect_pc[1:0] != 2'b00) begin
                        state_nxt = FAULT;
                        fault_nxt = 1'b1;
                    end else begin
                        pc_nxt = {redirect_pc[31:2], 2'b00};
                    end
`else
                    pc_nxt = {redirect_pc[31:2], 2'b00};
`endif
                end else if (advance) begin
                    out_pc_nxt  = pc;
                    out_ins_nxt = imem_ins;
                    valid_nxt   = 1'b1;
                    pc_nxt      = pc + 32'd4;
                end
            end

            FAULT: begin
                // Sticky until reset; all inputs ignored, PC frozen.
                valid_nxt = 1'b0;
                fault_nxt = 1'b1;
            end

            default: begin
                state_nxt = BOOT;
            end
        endcase
`ifndef IFETCH_MISALIGN_TRAP_EN
        fault_nxt = 1'b0;
`endif
    end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  logic        clk;
  logic        rst_n;
  logic [4:0]  imem_addr;
  logic [31:0] imem_ins;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_ins;
  logic        fault;

  int checks;
  int failures;

  instruction_fetch #(
    .ADDR_WIDTH(5),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_ins      (imem_ins),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_ins       (out_ins),
    .fault         (fault)
  );

  // memory model
  assign imem_ins = 32'hA000_0000 | {27'd0, imem_addr};

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // advance one clock edge, then settle away from the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] pc_e, input logic [31:0] ins_e);
    check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, ".pc"}, out_pc, pc_e);
    check({tag, ".ins"}, out_ins, ins_e);
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step();
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst_n          = 1'b0;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;

    // reset for two edges
    step();
    step();
    check("rst.valid", {31'd0, out_valid}, 32'd0);
    check("rst.pc", out_pc, 32'd0);
    check("rst.ins", out_ins, 32'h0000_0013);
    check("rst.fault", {31'd0, fault}, 32'd0);
    check("rst.addr", {27'd0, imem_addr}, 32'd0);

    // release; redirect offered during BOOT must be ignored
    rst_n = 1'b1;
    redirect(32'h0000_0040);
    check("boot.valid", {31'd0, out_valid}, 32'd0);
    check("boot.addr", {27'd0, imem_addr}, 32'd0);

    // stream
    step(); expect_out("s0", 32'h0, 32'hA000_0000);
    step(); expect_out("s1", 32'h4, 32'hA000_0001);
    step(); expect_out("s2", 32'h8, 32'hA000_0002);

    // backpressure
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); expect_out("stall", 32'h8, 32'hA000_0002);
    end
    out_ready = 1'b1;
    step(); expect_out("unstall", 32'hC, 32'hA000_0003);

    // redirect with a handshake in the same cycle
    redirect(32'h0000_0040);
    check("redir.valid", {31'd0, out_valid}, 32'd0);
    check("redir.addr", {27'd0, imem_addr}, 32'h10);
    step(); expect_out("redir0", 32'h40, 32'hA000_0010);
    step(); expect_out("redir1", 32'h44, 32'hA000_0011);

    // memory-index wrap
    redirect(32'h0000_007C);
    check("wrap.valid", {31'd0, out_valid}, 32'd0);
    step(); expect_out("wrap0", 32'h7C, 32'hA000_001F);
    step(); expect_out("wrap1", 32'h80, 32'hA000_0000);
    step(); expect_out("wrap2", 32'h84, 32'hA000_0001);

    // redirect beats a stall
    out_ready = 1'b0;
    redirect(32'h0000_0020);
    check("rstall.valid", {31'd0, out_valid}, 32'd0);
    step(); expect_out("rstall0", 32'h20, 32'hA000_0008);
    step(); expect_out("rstall1", 32'h20, 32'hA000_0008);
    out_ready = 1'b1;

    // 32-bit PC wrap
    redirect(32'hFFFF_FFFC);
    step(); expect_out("pcwrap0", 32'hFFFF_FFFC, 32'hA000_001F);
    step(); expect_out("pcwrap1", 32'h0, 32'hA000_0000);

    // misaligned redirect
    redirect(32'h0000_0042);
`ifdef IFETCH_MISALIGN_TRAP_EN
    check("mis.fault", {31'd0, fault}, 32'd1);
    check("mis.valid", {31'd0, out_valid}, 32'd0);
    redirect(32'h0000_0010);
    step();
    check("mis.hold_fault", {31'd0, fault}, 32'd1);
    check("mis.hold_valid", {31'd0, out_valid}, 32'd0);
`else
    check("mis.valid", {31'd0, out_valid}, 32'd0);
    step(); expect_out("mis", 32'h40, 32'hA000_0010);
    check("mis.fault", {31'd0, fault}, 32'd0);
`endif

    // reset while stalled
    out_ready = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    check("mrst.valid", {31'd0, out_valid}, 32'd0);
    check("mrst.fault", {31'd0, fault}, 32'd0);
    check("mrst.pc", out_pc, 32'd0);
    check("mrst.ins", out_ins, 32'h0000_0013);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    step();
    check("mrst.boot", {31'd0, out_valid}, 32'd0);
    step(); expect_out("mrst0", 32'h0, 32'hA000_0000);
    step(); expect_out("mrst1", 32'h4, 32'hA000_0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
